mac_scheduler: RTL and testbench

MAC_SCHEDULER -- requirements
Module: mac_scheduler

---
 rtl/mac_sched_pkg.sv | 19 +
 rtl/nibble_mul.sv | 10 +
 rtl/mac_scheduler.sv | 118 +++++++++++
 tb/tb_mac_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared state encoding and parameter defaults for mac_scheduler
package mac_sched_pkg;

    localparam int N_TERMS_DEF = 8;
    localparam int ACC_W_DEF   = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter must hold the value N after the final accept, hence n+1.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nibble_mul.sv
// rtl/nibble_mul.sv - combinational 4x4 unsigned multiplier
module nibble_mul (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_prod
);

    assign o_prod = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/mac_scheduler.sv
// rtl/mac_scheduler.sv - time-shared dot product of N_TERMS nibble pairs over one multiplier
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    localparam int                CNT_W    = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_TERMS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_prod;
    logic               r_prod_vld;
    logic [ACC_W-1:0]   r_acc;

    logic               w_accept;
    logic               w_last;
    logic               w_clear;
    logic [7:0]         w_prod;

    nibble_mul u_mul (
        .i_a    (in_data[3:0]),
        .i_b    (in_data[7:4]),
        .o_prod (w_prod)
    );

    assign in_ready = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign w_accept = in_valid & in_ready;
    // The counter is zero in IDLE, so a single-term build takes the DRAIN branch on its first accept.
    assign w_last   = (r_cnt == LAST_IDX);
    assign out_data = out_valid ? r_acc : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next = w_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Abort wins over any accept or result handshake in the same cycle.
        if (abort) begin
            w_next  = ST_IDLE;
            w_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (w_clear) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_accept) begin
                r_prod     <= w_prod;
                r_prod_vld <= 1'b1;
                r_cnt      <= r_cnt + CNT_W'(1);
            end else begin
                r_prod_vld <= 1'b0;
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + ACC_W'(r_prod);
            end
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// tb/tb_mac_scheduler.sv - randomized scoreboard bench for mac_scheduler
module tb_mac_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [10:0] out_data;

    logic        in_valid1 = 1'b0;
    logic [7:0]  in_data1 = 8'h00;
    logic        abort1 = 1'b0;
    logic        out_ready1 = 1'b1;
    logic        in_ready1;
    logic        out_valid1;
    logic        busy1;
    logic [7:0]  out_data1;

    mac_scheduler #(.N_TERMS(N), .ACC_W(11)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    mac_scheduler #(.N_TERMS(1), .ACC_W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .abort     (abort1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int data;
        int acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   terms[$];
    bit   rdy_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: a job is the sum of a*b over N consecutive accepted pairs.
    task automatic model_accept(input logic [7:0] d, input int e);
        int sum;
        exp_t x;
        terms.push_back(int'(d[3:0]) * int'(d[7:4]));
        if (terms.size() == N) begin
            sum = 0;
            foreach (terms[i]) sum += terms[i];
            x.data = sum;
            x.acc_edge = e;
            exp_q.push_back(x);
            terms.delete();
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic drive_pair(input logic [7:0] d, input int max_gap);
        int g;
        int e;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (in_ready) begin
                e = cyc + 1;
                @(posedge clk);
                model_accept(d, e);
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    // Monitor: compares each new result against the scoreboard and checks output protocol.
    logic        p_valid = 1'b0;
    logic        p_hs = 1'b0;
    logic        p_hold = 1'b0;
    logic [10:0] p_data = '0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            p_valid = 1'b0;
            p_hs    = 1'b0;
            p_hold  = 1'b0;
        end else begin
            if (!out_valid) check("data_zero_idle", 32'(out_data), 32'd0);
            if (p_hs) check("release_idle", {30'd0, out_valid, busy}, 32'd0);
            if (p_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(p_data));
            end
            if (out_valid) begin
                check("in_ready_done", 32'(in_ready), 32'd0);
                if (!p_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(out_data), 32'(e.data));
                        check("latency", 32'(cyc), 32'(e.acc_edge + 1));
                    end
                end
            end
            p_valid = out_valid;
            p_hs    = out_valid && out_ready && !abort;
            p_hold  = out_valid && !out_ready && !abort;
            p_data  = out_data;
        end
    end

    always @(negedge clk) begin
        if (rdy_rand) out_ready = 1'($urandom_range(1, 0));
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq [8];
        logic [7:0] one [4];
        bit seen;
        seq = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98};
        one = '{8'hF3, 8'hFF, 8'h00, 8'h5A};

        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst1_in_ready", 32'(in_ready1), 32'd1);
        #12 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) drive_pair(8'hFF, 0);
        wait_idle();

        for (int i = 0; i < 8; i++) drive_pair(seq[i], 3);
        wait_idle();

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_pair(8'($urandom), 1);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_reached", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        #3;
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        check("after_release_busy", 32'(busy), 32'd0);
        check("after_release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 4; i++) drive_pair(8'($urandom), 0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        terms.delete();
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #3;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) drive_pair(8'h11, 0);
        wait_idle();

        for (int i = 0; i < 3; i++) drive_pair(8'($urandom), 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        terms.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #3;
        check("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) drive_pair(8'h33, 0);
        wait_idle();

        rdy_rand = 1'b1;
        for (int j = 0; j < 12; j++) begin
            for (int k = 0; k < 8; k++) drive_pair(8'($urandom), $urandom_range(2, 0));
        end
        rdy_rand = 1'b0;
        @(negedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        foreach (one[i]) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = one[i];
            #3;
            check("n1_in_ready", 32'(in_ready1), 32'd1);
            @(negedge clk);
            in_valid1 = 1'b0;
            #3;
            check("n1_drain_busy", 32'(busy1), 32'd1);
            check("n1_drain_in_ready", 32'(in_ready1), 32'd0);
            check("n1_drain_valid", 32'(out_valid1), 32'd0);
            @(negedge clk);
            #3;
            check("n1_done_valid", 32'(out_valid1), 32'd1);
            check("n1_done_data", 32'(out_data1), 32'(int'(one[i][3:0]) * int'(one[i][7:4])));
            @(negedge clk);
            #3;
            check("n1_idle_busy", 32'(busy1), 32'd0);
            check("n1_idle_valid", 32'(out_valid1), 32'd0);
        end

        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
